// File: rtl/mod_n_digit_counter.sv
// mod_n_digit_counter
//   One decimal/sexagesimal digit of a stopwatch datapath. Counts up or down
//   modulo MODULUS on a single clock; digits cascade through cnt_en/carry_out
//   rather than through derived clocks.
//
//   Optional build macro: MNDC_CARRY_REG_EN
//     undefined : carry_out is combinational (terminal step in the same cycle),
//                 so a cascade steps in lockstep on one edge.
//     defined   : carry_out is registered, asserting the cycle after the wrap;
//                 each cascaded stage then lags by one cycle.
//
//   Handshake note: there is no valid/ready pair here. A step happens on a
//   rising edge when run & cnt_en & ~load and the requested mode matches the
//   last accepted mode; load has priority over everything and is sampled
//   every cycle.
module mod_n_digit_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             cnt_en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             load_err,
    output logic             mode_chg
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    // Parameter legality, caught at elaboration
    generate
        if ((2 ** WIDTH) < MODULUS) begin : g_err_width
            $error("mod_n_digit_counter: WIDTH too small for MODULUS");
        end
        if (MODULUS < 2) begin : g_err_modulus
            $error("mod_n_digit_counter: MODULUS must be >= 2");
        end
        if ((RST_VAL < 0) || (RST_VAL > MODULUS - 1)) begin : g_err_rst
            $error("mod_n_digit_counter: RST_VAL out of range");
        end
    endgenerate

    logic             mode_q;
    logic [WIDTH-1:0] count_d;
    logic             mode_d;
    logic             load_err_d;
    logic             mode_chg_d;
    logic             load_ok;
    logic             step;
    logic             term;

    // Step qualification and terminal-count detection
    always_comb begin
        load_ok = (load_value <= MAX_V);
        step    = run & cnt_en & ~load & (mode == mode_q);
        term    = step & (mode_q ? (count == MAX_V) : (count == '0));
    end

    // State register: count, accepted mode and the two status pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= RST_V;
            mode_q   <= 1'b1;
            load_err <= 1'b0;
            mode_chg <= 1'b0;
        end else begin
            count    <= count_d;
            mode_q   <= mode_d;
            load_err <= load_err_d;
            mode_chg <= mode_chg_d;
        end
    end

    // Next-state: load, then mode-change hold, then up/down step with explicit wrap
    always_comb begin
        count_d    = count;
        mode_d     = mode_q;
        load_err_d = 1'b0;
        mode_chg_d = 1'b0;
        if (load) begin
            // A load also absorbs any pending mode change, so no hold cycle follows
            mode_d = mode;
            if (load_ok) begin
                count_d = load_value;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (mode != mode_q) begin
            mode_d     = mode;
            mode_chg_d = 1'b1;
        end else if (step) begin
            if (mode_q) begin
                count_d = (count == MAX_V) ? '0 : count + 1'b1;
            end else begin
                count_d = (count == '0) ? MAX_V : count - 1'b1;
            end
        end
    end

`ifdef MNDC_CARRY_REG_EN
    logic carry_q;

    // Registered carry for long cascades: asserts the cycle after the wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= term;
        end
    end

    // Output: registered carry
    always_comb begin
        carry_out = carry_q;
    end
`else
    // Output: combinational carry, same cycle as the wrapping edge
    always_comb begin
        carry_out = term;
    end
`endif

endmodule

// File: tb/tb_mod_n_digit_counter.sv
// Directed bench for mod_n_digit_counter: one MODULUS=10 digit and a
// two-digit MODULUS=6 cascade. Expected carry timing follows MNDC_CARRY_REG_EN.
module tb_mod_n_digit_counter;

`ifdef MNDC_CARRY_REG_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       run;
    logic       cnt_en;
    logic       mode;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] count;
    logic       carry_out;
    logic       load_err;
    logic       mode_chg;

    logic       run6;
    logic       one6;
    logic       mode6;
    logic       load6;
    logic [2:0] lv6;
    logic [2:0] ls_count;
    logic [2:0] ms_count;
    logic       ls_carry;
    logic       ms_carry;
    logic       ls_err, ms_err, ls_chg, ms_chg;

    int n_checks;
    int n_fail;

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    mod_n_digit_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(0)) u_dut (
        .clk(clk), .reset(reset), .run(run), .cnt_en(cnt_en), .mode(mode),
        .load(load), .load_value(load_value), .count(count),
        .carry_out(carry_out), .load_err(load_err), .mode_chg(mode_chg)
    );

    mod_n_digit_counter #(.WIDTH(3), .MODULUS(6), .RST_VAL(0)) u_ls (
        .clk(clk), .reset(reset), .run(run6), .cnt_en(one6), .mode(mode6),
        .load(load6), .load_value(lv6), .count(ls_count),
        .carry_out(ls_carry), .load_err(ls_err), .mode_chg(ls_chg)
    );

    mod_n_digit_counter #(.WIDTH(3), .MODULUS(6), .RST_VAL(0)) u_ms (
        .clk(clk), .reset(reset), .run(run6), .cnt_en(ls_carry), .mode(mode6),
        .load(load6), .load_value(lv6), .count(ms_count),
        .carry_out(ms_carry), .load_err(ms_err), .mode_chg(ms_chg)
    );

    // Scoreboard check
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver: one-cycle load request issued at negedge
    task automatic do_load(input logic [3:0] v, input logic m);
        @(negedge clk);
        load       = 1'b1;
        load_value = v;
        mode       = m;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    initial begin
        int ls_e, ms_e;
        bit creg, inc, wrap;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0; run = 1'b0; cnt_en = 1'b0; mode = 1'b1;
        load = 1'b0; load_value = '0;
        run6 = 1'b0; one6 = 1'b1; mode6 = 1'b1; load6 = 1'b0; lv6 = '0;

        // Test 1: reset values, then asynchronous reset mid-count
        #3;
        chk("rst_count", count, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_mode_chg", mode_chg, 0);
        chk("rst_carry", carry_out, 0);
        #9 reset = 1'b1;
        do_load(4'd7, 1'b1);
        @(negedge clk);
        chk("t1_loaded7", count, 7);
        #2 reset = 1'b0;
        #1;
        chk("t1_async_count", count, 0);
        chk("t1_async_load_err", load_err, 0);
        chk("t1_async_mode_chg", mode_chg, 0);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Test 2: count up 12 clocks, carry only around count==9
        run = 1'b1; cnt_en = 1'b1; mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t2_count", count, i % 10);
            chk("t2_carry", carry_out, REG ? (i == 10) : ((i % 10) == 9));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("t2_final", count, 2);

        // Test 3: load 0 with mode down together (no hold), then borrow to 9
        do_load(4'd0, 1'b0);
        @(negedge clk);
        chk("t3_count0", count, 0);
        chk("t3_no_hold", mode_chg, 0);
        chk("t3_borrow", carry_out, REG ? 0 : 1);
        @(negedge clk);
        chk("t3_count9", count, 9);
        chk("t3_borrow_late", carry_out, REG ? 1 : 0);
        chk("t3_mode_chg", mode_chg, 0);
        run = 1'b0;

        // Test 4: illegal loads rejected, legal loads accepted, with run=0
        do_load(4'd12, 1'b0);
        @(negedge clk);
        chk("t4_hold12", count, 9);
        chk("t4_err12", load_err, 1);
        chk("t4_carry_run0", carry_out, 0);
        @(negedge clk);
        chk("t4_err_pulse", load_err, 0);
        do_load(4'd10, 1'b0);
        @(negedge clk);
        chk("t4_hold10", count, 9);
        chk("t4_err10", load_err, 1);
        do_load(4'd5, 1'b0);
        @(negedge clk);
        chk("t4_load5", count, 5);
        chk("t4_err5", load_err, 0);
        do_load(4'd9, 1'b0);
        @(negedge clk);
        chk("t4_load_max", count, 9);
        chk("t4_err_max", load_err, 0);

        // Test 5: mode flip at count 4 holds one cycle, then counts down
        do_load(4'd3, 1'b1);
        run = 1'b1; cnt_en = 1'b1; mode = 1'b1;
        @(negedge clk);
        chk("t5_count3", count, 3);
        chk("t5_no_chg", mode_chg, 0);
        @(negedge clk);
        chk("t5_count4", count, 4);
        mode = 1'b0;
        @(negedge clk);
        chk("t5_hold4", count, 4);
        chk("t5_chg", mode_chg, 1);
        chk("t5_carry", carry_out, 0);
        @(negedge clk);
        chk("t5_count3_down", count, 3);
        chk("t5_chg_pulse", mode_chg, 0);
        cnt_en = 1'b0;
        @(negedge clk);
        chk("t5_cnt_en0", count, 3);
        run = 1'b0;

        // Test 6: two-digit MODULUS=6 cascade, 40 clocks
        ls_e = 0; ms_e = 0; creg = 1'b0;
        @(negedge clk);
        chk("t6_ls_init", ls_count, 0);
        chk("t6_ms_init", ms_count, 0);
        run6 = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            wrap = (ls_e == 5);
            inc  = REG ? creg : wrap;
            creg = wrap;
            ls_e = (ls_e + 1) % 6;
            if (inc) ms_e = (ms_e + 1) % 6;
            @(negedge clk);
            chk("t6_ls", ls_count, ls_e);
            chk("t6_ms", ms_count, ms_e);
        end
        run6 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
